// File: rtl/y86_regfile_fwd_if.sv
// Decode-stage register-file bundle: pipeline-stage inputs and decoded/forwarded outputs.
// master drives the pipeline side, slave is the register file.
interface y86_regfile_fwd_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        D_icode, D_rA, D_rB;
    logic [DATA_W-1:0] D_valP;
    logic [3:0]        E_icode, E_destM;
    logic [3:0]        e_destE;
    logic [DATA_W-1:0] e_valE;
    logic [3:0]        M_destE, M_destM;
    logic [DATA_W-1:0] M_valE, m_valM;
    logic [3:0]        W_destE, W_destM;
    logic [DATA_W-1:0] W_valE, W_valM;
    logic [3:0]        dbg_sel;
    logic [3:0]        d_srcA, d_srcB, d_destE, d_destM;
    logic [DATA_W-1:0] d_valA, d_valB;
    logic              load_use_stall;
    logic [DATA_W-1:0] dbg_val;
    logic [31:0]       wr_count;

    modport master (
        output D_icode, D_rA, D_rB, D_valP, E_icode, E_destM, e_destE, e_valE,
               M_destE, M_destM, M_valE, m_valM, W_destE, W_destM, W_valE, W_valM, dbg_sel,
        input  d_srcA, d_srcB, d_destE, d_destM, d_valA, d_valB, load_use_stall, dbg_val, wr_count
    );
    modport slave (
        input  D_icode, D_rA, D_rB, D_valP, E_icode, E_destM, e_destE, e_valE,
               M_destE, M_destM, M_valE, m_valM, W_destE, W_destM, W_valE, W_valM, dbg_sel,
        output d_srcA, d_srcB, d_destE, d_destM, d_valA, d_valB, load_use_stall, dbg_val, wr_count
    );
endinterface

// File: rtl/y86_regfile_fwd.sv
// Y86-64 decode stage: ID decode, two forwarded operand reads, dual write-back port,
// load-use detection, debug read port and a count of cycles that wrote a register.
module y86_regfile_fwd #(
    parameter int                DATA_W   = 64,
    parameter int                NREG     = 15,
    parameter logic [3:0]        RNONE    = 4'hF,
    parameter int                RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = 254
) (
    input  logic            clk,
    input  logic            rst,
    y86_regfile_fwd_if.slave bus
);
    localparam logic [3:0] ICMOV = 4'h2, IIRMOV = 4'h3, IRMMOV = 4'h4, IMRMOV = 4'h5,
                           IOPQ  = 4'h6, IJXX   = 4'h7, ICALL  = 4'h8, IRET   = 4'h9,
                           IPUSH = 4'hA, IPOP   = 4'hB;
    localparam logic [3:0] RSP = 4'(RSP_IDX);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [31:0]       wr_count_q, wr_count_d;
    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] raw_a, raw_b, raw_dbg, val_a, val_b;
    logic              wr_e, wr_m;

    function automatic logic in_range(input logic [3:0] id);
        return (32'(id) < NREG) && (id != RNONE);
    endfunction

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        unique case (bus.D_icode)
            ICMOV:  begin src_a = bus.D_rA; dst_e = bus.D_rB; end
            IIRMOV: dst_e = bus.D_rB;
            IRMMOV: begin src_a = bus.D_rA; src_b = bus.D_rB; end
            IMRMOV: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
            IOPQ:   begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
            ICALL:  begin src_b = RSP; dst_e = RSP; end
            IRET:   begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            IPUSH:  begin src_a = bus.D_rA; src_b = RSP; dst_e = RSP; end
            IPOP:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = bus.D_rA; end
            default: ;
        endcase
    end

    always_comb begin
        raw_a   = '0;
        raw_b   = '0;
        raw_dbg = '0;
        for (int i = 0; i < NREG; i++) begin
            if (in_range(src_a) && src_a == 4'(i))       raw_a   = regs_q[i];
            if (in_range(src_b) && src_b == 4'(i))       raw_b   = regs_q[i];
            if (in_range(bus.dbg_sel) && bus.dbg_sel == 4'(i)) raw_dbg = regs_q[i];
        end
    end

    // Youngest producer wins: e, then M (load result before ALU), then W.
    always_comb begin
        if (bus.D_icode == IJXX || bus.D_icode == ICALL)         val_a = bus.D_valP;
        else if (src_a != RNONE && src_a == bus.e_destE)        val_a = bus.e_valE;
        else if (src_a != RNONE && src_a == bus.M_destM)        val_a = bus.m_valM;
        else if (src_a != RNONE && src_a == bus.M_destE)        val_a = bus.M_valE;
        else if (src_a != RNONE && src_a == bus.W_destM)        val_a = bus.W_valM;
        else if (src_a != RNONE && src_a == bus.W_destE)        val_a = bus.W_valE;
        else                                                    val_a = raw_a;

        if (src_b != RNONE && src_b == bus.e_destE)             val_b = bus.e_valE;
        else if (src_b != RNONE && src_b == bus.M_destM)        val_b = bus.m_valM;
        else if (src_b != RNONE && src_b == bus.M_destE)        val_b = bus.M_valE;
        else if (src_b != RNONE && src_b == bus.W_destM)        val_b = bus.W_valM;
        else if (src_b != RNONE && src_b == bus.W_destE)        val_b = bus.W_valE;
        else                                                    val_b = raw_b;
    end

    // M port applied after E so a popq %rsp keeps the loaded value.
    always_comb begin
        wr_e = in_range(bus.W_destE);
        wr_m = in_range(bus.W_destM);
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_e && bus.W_destE == 4'(i)) regs_d[i] = bus.W_valE;
            if (wr_m && bus.W_destM == 4'(i)) regs_d[i] = bus.W_valM;
        end
        wr_count_d = (wr_e || wr_m) ? wr_count_q + 32'd1 : wr_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
            wr_count_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.d_srcA         = src_a;
    assign bus.d_srcB         = src_b;
    assign bus.d_destE        = dst_e;
    assign bus.d_destM        = dst_m;
    assign bus.d_valA         = val_a;
    assign bus.d_valB         = val_b;
    assign bus.dbg_val        = raw_dbg;
    assign bus.wr_count       = wr_count_q;
    assign bus.load_use_stall = (bus.E_icode == IMRMOV || bus.E_icode == IPOP) &&
                                (bus.E_destM != RNONE) &&
                                (bus.E_destM == src_a || bus.E_destM == src_b);
endmodule

// File: tb/tb_y86_regfile_fwd.sv
// Bench for y86_regfile_fwd: directed scenarios plus randomized traffic against a
// table-driven model of decode, forwarding priority and the register array.
module tb_y86_regfile_fwd;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    y86_regfile_fwd_if #(.DATA_W(64)) bus ();

    y86_regfile_fwd #(.DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] m_reg [16];
    int unsigned m_cnt;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 64'd0;
        m_reg[4] = 64'd254;
        m_cnt = 0;
    endfunction

    function automatic logic [63:0] m_raw(input logic [3:0] s);
        return (s < 4'd15) ? m_reg[s] : 64'd0;
    endfunction

    function automatic void m_decode(output logic [3:0] sa, output logic [3:0] sb,
                                     output logic [3:0] de, output logic [3:0] dm);
        logic [3:0] a, b;
        a = bus.D_rA; b = bus.D_rB;
        sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
        case (bus.D_icode)
            4'h2: begin sa = a; de = b; end
            4'h3: de = b;
            4'h4: begin sa = a; sb = b; end
            4'h5: begin sb = b; dm = a; end
            4'h6: begin sa = a; sb = b; de = b; end
            4'h8: begin sb = 4'd4; de = 4'd4; end
            4'h9: begin sa = 4'd4; sb = 4'd4; de = 4'd4; end
            4'hA: begin sa = a; sb = 4'd4; de = 4'd4; end
            4'hB: begin sa = 4'd4; sb = 4'd4; de = 4'd4; dm = a; end
            default: ;
        endcase
    endfunction

    function automatic logic [63:0] m_fwd(input logic [3:0] s, input logic port_a);
        logic [3:0]  dst [5];
        logic [63:0] val [5];
        if (port_a && (bus.D_icode == 4'h7 || bus.D_icode == 4'h8)) return bus.D_valP;
        dst = '{bus.e_destE, bus.M_destM, bus.M_destE, bus.W_destM, bus.W_destE};
        val = '{bus.e_valE,  bus.m_valM,  bus.M_valE,  bus.W_valM,  bus.W_valE};
        if (s == 4'hF) return m_raw(s);
        for (int k = 0; k < 5; k++) if (dst[k] == s) return val[k];
        return m_raw(s);
    endfunction

    function automatic void m_commit();
        logic any;
        any = 1'b0;
        if (bus.W_destE < 4'd15) begin m_reg[bus.W_destE] = bus.W_valE; any = 1'b1; end
        if (bus.W_destM < 4'd15) begin m_reg[bus.W_destM] = bus.W_valM; any = 1'b1; end
        if (any) m_cnt = m_cnt + 1;
    endfunction

    task automatic idle();
        bus.D_icode = 4'h1; bus.D_rA = 4'hF; bus.D_rB = 4'hF; bus.D_valP = 64'd0;
        bus.E_icode = 4'h1; bus.E_destM = 4'hF;
        bus.e_destE = 4'hF; bus.e_valE = 64'd0;
        bus.M_destE = 4'hF; bus.M_destM = 4'hF; bus.M_valE = 64'd0; bus.m_valM = 64'd0;
        bus.W_destE = 4'hF; bus.W_destM = 4'hF; bus.W_valE = 64'd0; bus.W_valM = 64'd0;
        bus.dbg_sel = 4'd0;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) m_commit();
        #1;
    endtask

    task automatic test_reset();
        bus.dbg_sel = 4'd4; #1;
        checks++; if (bus.dbg_val !== 64'd254) begin errors++; $display("FAIL rst_rsp got %0h exp %0h", bus.dbg_val, 64'd254); end
        bus.dbg_sel = 4'd0; #1;
        checks++; if (bus.dbg_val !== 64'd0) begin errors++; $display("FAIL rst_r0 got %0h exp 0", bus.dbg_val); end
        checks++; if (bus.wr_count !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.wr_count); end
        bus.dbg_sel = 4'hF; #1;
        checks++; if (bus.dbg_val !== 64'd0) begin errors++; $display("FAIL rst_rnone got %0h exp 0", bus.dbg_val); end
    endtask

    task automatic test_write_read();
        bus.W_destE = 4'd3; bus.W_valE = 64'h55;
        bus.D_icode = 4'h6; bus.D_rA = 4'd3; bus.D_rB = 4'hF;
        #1;
        checks++; if (bus.d_valA !== 64'h55) begin errors++; $display("FAIL wfwd got %0h exp 55", bus.d_valA); end
        step();
        bus.W_destE = 4'hF; bus.W_valE = 64'd0; bus.dbg_sel = 4'd3;
        #1;
        checks++; if (bus.d_valA !== 64'h55) begin errors++; $display("FAIL wraw got %0h exp 55", bus.d_valA); end
        checks++; if (bus.dbg_val !== 64'h55) begin errors++; $display("FAIL wdbg got %0h exp 55", bus.dbg_val); end
        checks++; if (bus.wr_count !== 32'd1) begin errors++; $display("FAIL wcnt got %0d exp 1", bus.wr_count); end
    endtask

    task automatic test_forward_priority();
        logic [63:0] exp_v [3];
        exp_v = '{64'h11, 64'h22, 64'h33};
        bus.D_icode = 4'h6; bus.D_rA = 4'd2; bus.D_rB = 4'd2;
        bus.e_destE = 4'd2; bus.e_valE = 64'h11;
        bus.M_destM = 4'd2; bus.m_valM = 64'h22;
        bus.W_destE = 4'd2; bus.W_valE = 64'h33;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) bus.e_destE = 4'hF;
            if (k == 2) bus.M_destM = 4'hF;
            #1;
            checks++; if (bus.d_valA !== exp_v[k]) begin errors++; $display("FAIL prioA%0d got %0h exp %0h", k, bus.d_valA, exp_v[k]); end
            checks++; if (bus.d_valB !== exp_v[k]) begin errors++; $display("FAIL prioB%0d got %0h exp %0h", k, bus.d_valB, exp_v[k]); end
        end
        bus.D_icode = 4'h8; bus.D_valP = 64'h1234; #1;
        checks++; if (bus.d_valA !== 64'h1234) begin errors++; $display("FAIL callvalP got %0h exp 1234", bus.d_valA); end
        step();
        idle();
    endtask

    task automatic test_popq_rsp();
        int unsigned c0;
        c0 = m_cnt;
        bus.W_destE = 4'd4; bus.W_destM = 4'd4; bus.W_valE = 64'h100; bus.W_valM = 64'h200;
        step();
        idle(); bus.dbg_sel = 4'd4; #1;
        checks++; if (bus.dbg_val !== 64'h200) begin errors++; $display("FAIL pop_rsp got %0h exp 200", bus.dbg_val); end
        checks++; if (bus.wr_count !== c0 + 1) begin errors++; $display("FAIL pop_cnt got %0d exp %0d", bus.wr_count, c0 + 1); end
    endtask

    task automatic test_load_use();
        bus.E_icode = 4'h5; bus.E_destM = 4'd1;
        bus.D_icode = 4'h6; bus.D_rA = 4'd1; bus.D_rB = 4'd7; #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_hit got %b exp 1", bus.load_use_stall); end
        bus.E_destM = 4'hF; #1;
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_none got %b exp 0", bus.load_use_stall); end
        bus.E_icode = 4'hB; bus.E_destM = 4'd7; #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_popB got %b exp 1", bus.load_use_stall); end
        bus.E_icode = 4'h6; #1;
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_alu got %b exp 0", bus.load_use_stall); end
        idle();
    endtask

    task automatic test_random();
        logic [3:0] sa, sb, de, dm;
        logic       stall;
        for (int n = 0; n < 400; n++) begin
            bus.D_icode = 4'($urandom_range(0, 15));
            bus.D_rA    = 4'($urandom_range(0, 15));
            bus.D_rB    = 4'($urandom_range(0, 15));
            bus.D_valP  = {$urandom, $urandom};
            bus.E_icode = 4'($urandom_range(0, 15));
            bus.E_destM = 4'($urandom_range(0, 15));
            bus.e_destE = 4'($urandom_range(0, 15)); bus.e_valE = {$urandom, $urandom};
            bus.M_destE = 4'($urandom_range(0, 15)); bus.M_valE = {$urandom, $urandom};
            bus.M_destM = 4'($urandom_range(0, 15)); bus.m_valM = {$urandom, $urandom};
            bus.W_destE = 4'($urandom_range(0, 15)); bus.W_valE = {$urandom, $urandom};
            bus.W_destM = 4'($urandom_range(0, 15)); bus.W_valM = {$urandom, $urandom};
            bus.dbg_sel = 4'($urandom_range(0, 15));
            #1;
            m_decode(sa, sb, de, dm);
            stall = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_destM != 4'hF &&
                    (bus.E_destM == sa || bus.E_destM == sb);
            checks++; if ({bus.d_srcA, bus.d_srcB, bus.d_destE, bus.d_destM} !== {sa, sb, de, dm}) begin
                errors++; $display("FAIL rnd_ids n=%0d got %h exp %h", n,
                    {bus.d_srcA, bus.d_srcB, bus.d_destE, bus.d_destM}, {sa, sb, de, dm}); end
            checks++; if (bus.d_valA !== m_fwd(sa, 1'b1)) begin errors++; $display("FAIL rnd_valA n=%0d got %h exp %h", n, bus.d_valA, m_fwd(sa, 1'b1)); end
            checks++; if (bus.d_valB !== m_fwd(sb, 1'b0)) begin errors++; $display("FAIL rnd_valB n=%0d got %h exp %h", n, bus.d_valB, m_fwd(sb, 1'b0)); end
            checks++; if (bus.load_use_stall !== stall) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, bus.load_use_stall, stall); end
            checks++; if (bus.dbg_val !== m_raw(bus.dbg_sel)) begin errors++; $display("FAIL rnd_dbg n=%0d got %h exp %h", n, bus.dbg_val, m_raw(bus.dbg_sel)); end
            checks++; if (bus.wr_count !== m_cnt) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d exp %0d", n, bus.wr_count, m_cnt); end
            step();
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 5; r++) begin
            bus.W_destE = 4'(r + 5); bus.W_valE = 64'hA0 + 64'(r);
            step();
        end
        idle();
        #2 rst = 1'b1;
        m_reset();
        #1;
        checks++; if (bus.wr_count !== 32'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", bus.wr_count); end
        for (int i = 0; i < 15; i++) begin
            bus.dbg_sel = 4'(i); #0.5;
            checks++; if (bus.dbg_val !== m_raw(4'(i))) begin errors++; $display("FAIL arst_r%0d got %0h exp %0h", i, bus.dbg_val, m_raw(4'(i))); end
        end
        bus.W_destE = 4'd5; bus.W_valE = 64'hDEAD;
        step();
        bus.dbg_sel = 4'd5; #1;
        checks++; if (bus.dbg_val !== 64'd0) begin errors++; $display("FAIL arst_ignwr got %0h exp 0", bus.dbg_val); end
        rst = 1'b0;
        bus.W_destE = 4'd3; bus.W_valE = 64'hABC;
        step();
        idle(); bus.dbg_sel = 4'd3; #1;
        checks++; if (bus.dbg_val !== 64'hABC) begin errors++; $display("FAIL arst_first got %0h exp abc", bus.dbg_val); end
        checks++; if (bus.wr_count !== 32'd1) begin errors++; $display("FAIL arst_cnt1 got %0d exp 1", bus.wr_count); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_reset();
        #12;
        test_reset();
        rst = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_forward_priority();
        test_popq_rsp();
        test_load_use();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
